// File: rtl/dp_mem_responder.sv
// rtl/dp_mem_responder.sv - arbitrated fixed-latency RAM responder for the instruction and data ports
// Data requests win over instruction requests; each access holds the RAM port for LAT cycles.

module dp_mem_responder #(
    parameter int LAT = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload
);

    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic          wen_q, wen_d;
    logic [31:0]   ihold_q, ihold_d;
    logic [31:0]   dhold_q, dhold_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wen_q   <= 1'b0;
            ihold_q <= '0;
            dhold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wen_q   <= wen_d;
            ihold_q <= ihold_d;
            dhold_q <= dhold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        wen_d   = wen_q;
        ihold_d = ihold_q;
        dhold_d = dhold_q;
        ihit    = 1'b0;
        dhit    = 1'b0;
        ramREN  = 1'b0;
        ramWEN  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dmemREN || dmemWEN) begin
                    state_d = DACC;
                    cnt_d   = '0;
                    addr_d  = dmemaddr;
                    store_d = dmemstore;
                    wen_d   = dmemWEN;
                end else if (imemREN && !halt) begin
                    state_d = IACC;
                    cnt_d   = '0;
                    addr_d  = imemaddr;
                end
            end
            IACC: begin
                ramREN = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    ihit    = 1'b1;
                    ihold_d = ramload;
                    state_d = IDLE;
                end
            end
            DACC: begin
                ramREN = !wen_q;
                ramWEN = wen_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    dhit    = 1'b1;
                    state_d = IDLE;
                    if (!wen_q) begin
                        dhold_d = ramload;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load data is forwarded from the RAM during the hit cycle, then replayed from the hold register.
    assign imemload = ihit ? ramload : ihold_q;
    assign dmemload = (dhit && !wen_q) ? ramload : dhold_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// tb/tb_dp_mem_responder.sv - scoreboard bench for dp_mem_responder at LAT 1, 2 and 3
// A transaction-level scheduler predicts each access window; a per-cycle monitor checks the DUT against it.

module tb_dp_mem_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] ramload;

    int cyc = 0;
    int n_pass = 0;
    int n_tot = 0;

    typedef struct {
        bit          d;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] store;
        int          start;
        int          hit;
    } acc_t;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int L = gi + 1;

        logic        ihit, dhit, ren, wen;
        logic [31:0] iload, dload, raddr, rstore;

        acc_t        q[$];
        int          next_free = 0;
        logic [31:0] e_ih = '0, e_dh = '0, e_addr = '0, e_store = '0;

        dp_mem_responder #(.LAT(L)) dut (
            .CLK      (CLK),
            .nRST     (nRST),
            .halt     (halt),
            .imemREN  (imemREN),
            .imemaddr (imemaddr),
            .ihit     (ihit),
            .imemload (iload),
            .dmemREN  (dmemREN),
            .dmemWEN  (dmemWEN),
            .dmemaddr (dmemaddr),
            .dmemstore(dmemstore),
            .dhit     (dhit),
            .dmemload (dload),
            .ramREN   (ren),
            .ramWEN   (wen),
            .ramaddr  (raddr),
            .ramstore (rstore),
            .ramload  (ramload)
        );

        task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
            n_tot++;
            if (got === exp) n_pass++;
            else $display("FAIL L=%0d %s cyc=%0d got=%h exp=%h", L, name, cyc, got, exp);
        endtask

        // Scheduler: an access accepted at the end of cycle k owns cycles k+1..k+L.
        always @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                q.delete();
                next_free = 0;
            end else if (cyc >= next_free) begin
                if (dmemREN || dmemWEN) begin
                    q.push_back('{1'b1, dmemWEN, dmemaddr, dmemstore, cyc + 1, cyc + L});
                    next_free = cyc + L + 1;
                end else if (imemREN && !halt) begin
                    q.push_back('{1'b0, 1'b0, imemaddr, 32'h0, cyc + 1, cyc + L});
                    next_free = cyc + L + 1;
                end
            end
        end

        always @(negedge CLK) begin
            bit          act, hitc, e_ren, e_wen, e_ihit, e_dhit;
            acc_t        a;
            logic [31:0] e_il, e_dl;
            act = 1'b0;
            if (!nRST) begin
                e_ih = '0; e_dh = '0; e_addr = '0; e_store = '0;
                chk("rst_ctl", {28'h0, ren, wen, ihit, dhit}, 32'h0);
                chk("rst_imemload", iload, 32'h0);
                chk("rst_dmemload", dload, 32'h0);
                chk("rst_ramaddr", raddr, 32'h0);
                chk("rst_ramstore", rstore, 32'h0);
            end else begin
                if (q.size() > 0) begin
                    a   = q[0];
                    act = (cyc >= a.start) && (cyc <= a.hit);
                end
                if (act && cyc == a.start) begin
                    e_addr = a.addr;
                    if (a.d) e_store = a.store;
                end
                hitc   = act && (cyc == a.hit);
                e_ren  = act && !(a.d && a.wen);
                e_wen  = act && a.d && a.wen;
                e_ihit = hitc && !a.d;
                e_dhit = hitc && a.d;
                e_il   = e_ihit ? ramload : e_ih;
                e_dl   = (e_dhit && !a.wen) ? ramload : e_dh;
                chk("ctl{ren,wen,ihit,dhit}", {28'h0, ren, wen, ihit, dhit},
                    {28'h0, e_ren, e_wen, e_ihit, e_dhit});
                chk("ramaddr", raddr, e_addr);
                chk("ramstore", rstore, e_store);
                chk("imemload", iload, e_il);
                chk("dmemload", dload, e_dl);
                e_ih = e_il;
                e_dh = e_dl;
                if (hitc) void'(q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        nRST = 1'b0; halt = 1'b0; imemREN = 1'b0; imemaddr = '0;
        dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0; ramload = '0;
        step(2);
        nRST = 1'b1;
        step(2);

        // Single instruction read
        imemREN = 1'b1; imemaddr = 32'h4; ramload = 32'h8C22_0000;
        step(1);
        imemREN = 1'b0;
        step(8);

        // Simultaneous instruction and data requests
        imemREN = 1'b1; imemaddr = 32'h10;
        dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'hDEAD_BEEF; ramload = 32'h1357_9BDF;
        step(1);
        dmemWEN = 1'b0;
        step(4);
        imemREN = 1'b0;
        step(8);

        // halt blocks instruction acceptance only
        halt = 1'b1; imemREN = 1'b1; imemaddr = 32'h20;
        step(10);
        dmemREN = 1'b1; dmemaddr = 32'h40; ramload = 32'h5;
        step(1);
        dmemREN = 1'b0; imemREN = 1'b0;
        step(1);
        halt = 1'b0;
        step(6);

        // Reset in the first cycle of a data read
        dmemREN = 1'b1; dmemaddr = 32'h80; ramload = 32'h1234_5678;
        step(1);
        dmemREN = 1'b0;
        #1 nRST = 1'b0;
        step(1);
        nRST = 1'b1;
        dmemREN = 1'b1; dmemaddr = 32'h84; ramload = 32'h0BAD_F00D;
        step(1);
        dmemREN = 1'b0;
        step(6);

        // Held instruction request
        imemREN = 1'b1; imemaddr = 32'h30; ramload = 32'h2468_ACE0;
        step(8);
        imemREN = 1'b0;
        step(6);

        // Data request dropped after one cycle
        dmemREN = 1'b1; dmemaddr = 32'h90; ramload = 32'hA5A5_A5A5;
        step(1);
        dmemREN = 1'b0;
        step(8);

        for (int i = 0; i < 800; i++) begin
            if (!nRST) nRST = 1'b1;
            dmemREN   = ($urandom_range(0, 99) < 15);
            dmemWEN   = ($urandom_range(0, 99) < 12);
            imemREN   = ($urandom_range(0, 99) < 60);
            halt      = ($urandom_range(0, 99) < 15);
            imemaddr  = $urandom;
            dmemaddr  = $urandom;
            dmemstore = $urandom;
            ramload   = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #1 nRST = 1'b0;
            end
            step(1);
        end
        nRST = 1'b1;
        dmemREN = 1'b0; dmemWEN = 1'b0; imemREN = 1'b0; halt = 1'b0;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for the pipelined datapath's instruction and data ports. It accepts `imemREN`, `dmemREN` and `dmemWEN` requests and arbitrates them onto a single fixed-latency RAM port. It returns the single-cycle `ihit`/`dhit` pulses and load data that the hazard unit and the pipeline latches consume. It sits between the datapath and the RAM, in place of a zero-wait memory model.

## Interface
- `LAT`, default 2: RAM access latency in cycles. Legal values are 1 and above.
- `CLK`, in, 1: clock, rising edge.
- `nRST`, in, 1: reset, asynchronous, active-low.
- `halt`, in, 1: datapath halted. Instruction requests are ignored while this is high.
- `imemREN`, in, 1: instruction read request.
- `imemaddr`, in, 32: instruction address.
- `ihit`, out, 1: instruction access complete. One-cycle pulse.
- `imemload`, out, 32: instruction word.
- `dmemREN`, in, 1: data read request.
- `dmemWEN`, in, 1: data write request.
- `dmemaddr`, in, 32: data address.
- `dmemstore`, in, 32: write data.
- `dhit`, out, 1: data access complete. One-cycle pulse.
- `dmemload`, out, 32: data read word.
- `ramREN`, out, 1: RAM read enable.
- `ramWEN`, out, 1: RAM write enable.
- `ramaddr`, out, 32: RAM address.
- `ramstore`, out, 32: RAM write data.
- `ramload`, in, 32: RAM read data. Valid in the final cycle of a read access.

## Operation
- **States.** IDLE, IACC, DACC. The block also holds:
  - a counter `cnt` of width $clog2(LAT+1);
  - latched copies of address, store data and the WEN flag;
  - two hold registers, `ihold` and `dhold`.
- **IDLE, choosing an access.** Evaluated at each clock edge.
  - `dmemREN | dmemWEN` → DACC. Latch `dmemaddr` and `dmemstore`. Latch WEN = `dmemWEN`; if both REN and WEN are high, WEN wins.
  - Otherwise, `imemREN & ~halt` → IACC. Latch `imemaddr`.
  - Otherwise stay in IDLE.
  - On both transitions, `cnt` ← 0.
- **Arbitration.** Data has fixed priority over instruction. An instruction request that arrives while DACC is busy waits. There is no preemption of an access already in progress.
- **IACC and DACC.**
  - `ramaddr` is driven from the latched address. `ramstore` is driven from the latched store data.
  - IACC drives `ramREN`=1.
  - DACC drives `ramREN`=~WEN and `ramWEN`=WEN.
  - `cnt` increments each cycle.
  - When `cnt == LAT-1`, the hit for the current state is asserted combinationally and the next state is IDLE.
- **Load data.**
  - During `ihit`, `imemload` = `ramload`, and `ihold` captures `ramload` at that edge.
  - During a read `dhit`, `dmemload` = `ramload`, and `dhold` captures it.
  - At all other times `imemload` = `ihold` and `dmemload` = `dhold`.
  - Write accesses leave `dhold` unchanged.
- **No abort.** If a requester drops its enable mid-access, the access still completes and the hit still pulses.
- **Request after a hit.** A request still asserted in the IDLE cycle after a hit is treated as a new access. The datapath must have advanced, or deasserted its request, by then.
- **halt.** Affects only acceptance in IDLE. An IACC already in progress completes.
- **Idle outputs.** In IDLE: `ramREN`=`ramWEN`=0, `ihit`=`dhit`=0. `ramaddr` and `ramstore` hold their last latched values.
- **Mutual exclusion.** `ihit` and `dhit` are never high in the same cycle. `ramREN` and `ramWEN` are never high in the same cycle.

## Timing
- **Reset values.** All outputs 0, state IDLE, `cnt` 0, latches 0, `ihold` and `dhold` 0.
- **Reset mid-access.** Asserting `nRST` low during an access forces `ramREN`/`ramWEN`/hits low immediately, without waiting for a clock edge. The access is dropped and no hit is issued.
- **Latency.** A request sampled in IDLE at edge 0 gives RAM enables in cycles 1..LAT and the hit in cycle LAT.
- **Back-to-back.** Accesses need one IDLE cycle between them. Peak throughput is one access per LAT+1 cycles.
- **Simultaneous requests.** With instruction and data requesting together, `dhit` comes in cycle LAT and `ihit` in cycle 2·LAT+1.

## Test plan
- **Single instruction read.**
  - Stimulus: LAT=2, `imemREN`=1, `imemaddr`=0x4, `ramload`=0x8C220000.
  - Required: `ramREN`=1 and `ramaddr`=0x4 in cycles 1–2; `ihit`=1 in cycle 2 only; `imemload`=0x8C220000 from cycle 2 onward.
- **Simultaneous instruction and data requests.**
  - Stimulus: LAT=2, `imemREN` at 0x10, `dmemWEN` at 0x200 with store data 0xDEADBEEF, both from cycle 0.
  - Required: `ramWEN`=1 with `ramaddr`=0x200 and `ramstore`=0xDEADBEEF in cycles 1–2; `dhit` in cycle 2; `ramREN` at 0x10 in cycles 4–5; `ihit` in cycle 5; no hit in any other cycle.
- **halt.**
  - Stimulus: `halt`=1, `imemREN`=1 for 10 cycles; then `dmemREN` at 0x40 with `ramload`=0x5.
  - Required: no RAM enable and no `ihit` during the 10 cycles; then `dhit` after LAT cycles with `dmemload`=0x5.
- **Reset mid-access.**
  - Stimulus: `nRST` pulsed low in cycle 1 of a DACC read.
  - Required: `ramREN`=0, `dhit`=0 and `dmemload`=0 immediately with the reset; the next request after reset completes with normal LAT timing.
- **LAT=1, held request.**
  - Stimulus: LAT=1, `imemREN` held high for 8 cycles.
  - Required: `ihit` high in cycles 1, 3, 5, 7; `ramREN` high only in those cycles.
- **Request dropped mid-access.**
  - Stimulus: LAT=3, `dmemREN` asserted in cycle 0 only, `ramload`=0xA5A5A5A5.
  - Required: `ramREN` high in cycles 1–3; `dhit` in cycle 3; `dmemload`=0xA5A5A5A5 held afterward; state IDLE in cycle 4.
